// File: rtl/ts_sync_recovery_param_if.sv
// Byte-stream bus for the TS sync recovery block.
// The source side (master) drives bytes in; the recovery block (slave)
// returns the re-timed bytes with packet-alignment flags.
interface ts_sync_recovery_param_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       valid;
  logic       sync;
  logic       locked;
  logic       sync_miss;

  modport master (
    output byte_in, byte_valid,
    input  byte_out, valid, sync, locked, sync_miss
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_out, valid, sync, locked, sync_miss
  );
endinterface

// File: rtl/ts_sync_recovery_param.sv
// MPEG-2 TS sync recovery with flywheel hysteresis, one channel.
// Hunts for SYNC_BYTE, confirms it at PKT_LEN spacing, locks after LOCK_CNT
// confirmations and only re-hunts after UNLOCK_CNT consecutive misses.
// Optional macro TS_SYNC_STATS_EN adds saturating lock_loss_cnt / pkt_cnt.
module ts_sync_recovery_param #(
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3,
  parameter int         POS_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  ts_sync_recovery_param_if.slave    bus
`ifdef TS_SYNC_STATS_EN
 ,output logic [15:0]                lock_loss_cnt
 ,output logic [31:0]                pkt_cnt
`endif
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PKT_LEN - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [3:0]       LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_C = 4'(UNLOCK_CNT);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_nxt;
  logic [3:0]       hit_q, hit_d, miss_q, miss_d;
  logic             sync_d, smiss_d;
  logic             is_sync;

  logic [7:0]       byte_p1;
  logic             vld_p1, sync_p1, locked_p1, smiss_p1;

  assign is_sync = (bus.byte_in == SYNC_BYTE);
  assign pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;

  // Next-state: hunt / verify / flywheel decisions, only on accepted bytes
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    sync_d  = 1'b0;
    smiss_d = 1'b0;
    if (bus.byte_valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            pos_d   = POS_ONE;
            hit_d   = '0;
          end
        end
        VERIFY: begin
          if (pos_q != '0) begin
            pos_d = pos_nxt;
          end else if (is_sync) begin
            hit_d = hit_q + 4'd1;
            pos_d = POS_ONE;
            if (hit_q + 4'd1 == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
              sync_d  = 1'b1;
            end
          end else begin
            // Mismatching boundary byte is dropped, not reused as a candidate
            state_d = HUNT;
            hit_d   = '0;
            pos_d   = '0;
          end
        end
        LOCKED: begin
          pos_d = pos_nxt;
          if (pos_q == '0) begin
            if (is_sync) begin
              sync_d = 1'b1;
              miss_d = '0;
            end else begin
              smiss_d = 1'b1;
              miss_d  = miss_q + 4'd1;
              if (miss_q + 4'd1 == UNLOCK_C) begin
                state_d = HUNT;
                pos_d   = '0;
                hit_d   = '0;
              end else begin
                // Flywheel: keep marking the expected boundary
                sync_d = 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // ---- stage p1: control state and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      pos_q     <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      byte_p1   <= '0;
      vld_p1    <= 1'b0;
      sync_p1   <= 1'b0;
      locked_p1 <= 1'b0;
      smiss_p1  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      byte_p1   <= bus.byte_valid ? bus.byte_in : '0;
      vld_p1    <= bus.byte_valid;
      sync_p1   <= sync_d;
      locked_p1 <= (state_d == LOCKED);
      smiss_p1  <= smiss_d;
    end
  end

  assign bus.byte_out  = byte_p1;
  assign bus.valid     = vld_p1;
  assign bus.sync      = sync_p1;
  assign bus.locked    = locked_p1;
  assign bus.sync_miss = smiss_p1;

`ifdef TS_SYNC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic lock_lost;
  assign lock_lost = bus.byte_valid && (state_q == LOCKED) && (state_d == HUNT);

  // Saturating statistics, updated alongside the p1 outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
      pkt_cnt       <= '0;
    end else begin
      if (lock_lost) lock_loss_cnt <= sat_inc16(lock_loss_cnt);
      if (sync_d)    pkt_cnt       <= sat_inc32(pkt_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ts_sync_recovery_param.sv
// Bench for ts_sync_recovery_param: default instance (188/3/3) and a
// 204-byte instance with LOCK_CNT=UNLOCK_CNT=1. Stimulus is described as
// packet tables; the expected output of every byte is queued when driven
// and compared one cycle later.
module tb_ts_sync_recovery_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rsta = 1'b1;
  logic rstb = 1'b1;

  ts_sync_recovery_param_if ifa();
  ts_sync_recovery_param_if ifb();

`ifdef TS_SYNC_STATS_EN
  logic [15:0] lla, llb;
  logic [31:0] pca, pcb;
`endif

  ts_sync_recovery_param dut_a (
    .clk (clk),
    .rst (rsta),
    .bus (ifa)
`ifdef TS_SYNC_STATS_EN
   ,.lock_loss_cnt (lla)
   ,.pkt_cnt       (pca)
`endif
  );

  ts_sync_recovery_param #(
    .PKT_LEN    (204),
    .LOCK_CNT   (1),
    .UNLOCK_CNT (1)
  ) dut_b (
    .clk (clk),
    .rst (rstb),
    .bus (ifb)
`ifdef TS_SYNC_STATS_EN
   ,.lock_loss_cnt (llb)
   ,.pkt_cnt       (pcb)
`endif
  );

  typedef struct {
    logic [7:0] bo;
    logic       v;
    logic       s;
    logic       m;
    logic       l;
  } exp_t;

  typedef struct {
    logic [7:0] hdr;
    logic       s;
    logic       m;
    logic       l;
  } pkt_t;

  exp_t sbq[$];
  pkt_t cur[$];
  pkt_t tbl[17];

  int n_tests = 0;
  int n_fail  = 0;
  bit last_lk[2];
  int exp_pkt[2];
  int exp_loss[2];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pay();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r == 8'h47) r = 8'h00;
    return r;
  endfunction

  task automatic compare_out(input int sel);
    exp_t e;
    logic [7:0] ab;
    logic av, as, am, al;
    e = sbq.pop_front();
    if (sel == 0) begin
      ab = ifa.byte_out; av = ifa.valid; as = ifa.sync; am = ifa.sync_miss; al = ifa.locked;
    end else begin
      ab = ifb.byte_out; av = ifb.valid; as = ifb.sync; am = ifb.sync_miss; al = ifb.locked;
    end
    chk(sel == 0 ? "a.byte_out"  : "b.byte_out",  int'(ab), int'(e.bo));
    chk(sel == 0 ? "a.valid"     : "b.valid",     int'(av), int'(e.v));
    chk(sel == 0 ? "a.sync"      : "b.sync",      int'(as), int'(e.s));
    chk(sel == 0 ? "a.sync_miss" : "b.sync_miss", int'(am), int'(e.m));
    chk(sel == 0 ? "a.locked"    : "b.locked",    int'(al), int'(e.l));
`ifdef TS_SYNC_STATS_EN
    if (sel == 0) begin
      chk("a.lock_loss_cnt", int'(lla), exp_loss[0]);
      chk("a.pkt_cnt",       int'(pca), exp_pkt[0]);
    end else begin
      chk("b.lock_loss_cnt", int'(llb), exp_loss[1]);
      chk("b.pkt_cnt",       int'(pcb), exp_pkt[1]);
    end
`endif
  endtask

  // One input cycle on instance sel; expected flags apply only when v=1
  task automatic send(input int sel, input bit v, input logic [7:0] b,
                      input bit es, input bit em, input bit el);
    exp_t e;
    @(negedge clk);
    rsta = 1'b0;
    rstb = 1'b0;
    if (sel == 0) begin
      ifa.byte_valid = v; ifa.byte_in = b; ifb.byte_valid = 1'b0; ifb.byte_in = 8'h00;
    end else begin
      ifb.byte_valid = v; ifb.byte_in = b; ifa.byte_valid = 1'b0; ifa.byte_in = 8'h00;
    end
    e.bo = v ? b : 8'h00;
    e.v  = v;
    e.s  = v & es;
    e.m  = v & em;
    e.l  = v ? el : last_lk[sel];
    if (v) begin
      if (e.s) exp_pkt[sel]++;
      if (last_lk[sel] && !e.l) exp_loss[sel]++;
    end
    last_lk[sel] = e.l;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_out(sel);
  endtask

  // Reset with a valid sync byte presented in the same cycle: it must be dropped
  task automatic do_reset(input int sel);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      rsta = 1'b1; ifa.byte_valid = 1'b1; ifa.byte_in = 8'h47;
    end else begin
      rstb = 1'b1; ifb.byte_valid = 1'b1; ifb.byte_in = 8'h47;
    end
    e.bo = 8'h00; e.v = 1'b0; e.s = 1'b0; e.m = 1'b0; e.l = 1'b0;
    last_lk[sel]  = 1'b0;
    exp_pkt[sel]  = 0;
    exp_loss[sel] = 0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_out(sel);
  endtask

  // Plays the packets in cur[] on instance sel, optionally with random gaps
  task automatic run_pkts(input int sel, input int plen, input bit gaps);
    for (int i = 0; i < cur.size(); i++) begin
      for (int off = 0; off < plen; off++) begin
        if (gaps) begin
          for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++)
            send(sel, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        if (off == 0)
          send(sel, 1'b1, cur[i].hdr, cur[i].s, cur[i].m, cur[i].l);
        else
          send(sel, 1'b1, pay(), 1'b0, 1'b0, cur[i].l);
      end
    end
  endtask

  function automatic pkt_t mk(input logic [7:0] h, input bit s, input bit m, input bit l);
    pkt_t p;
    p.hdr = h; p.s = s; p.m = m; p.l = l;
    return p;
  endfunction

  initial begin
    // Lock, single miss, miss cleared, miss run broken, 3 misses unlock, re-lock
    tbl[0]  = mk(8'h47, 0, 0, 0);
    tbl[1]  = mk(8'h47, 0, 0, 0);
    tbl[2]  = mk(8'h47, 0, 0, 0);
    tbl[3]  = mk(8'h47, 1, 0, 1);
    tbl[4]  = mk(8'h47, 1, 0, 1);
    tbl[5]  = mk(8'h00, 1, 1, 1);
    tbl[6]  = mk(8'h47, 1, 0, 1);
    tbl[7]  = mk(8'h00, 1, 1, 1);
    tbl[8]  = mk(8'h00, 1, 1, 1);
    tbl[9]  = mk(8'h47, 1, 0, 1);
    tbl[10] = mk(8'h00, 1, 1, 1);
    tbl[11] = mk(8'h00, 1, 1, 1);
    tbl[12] = mk(8'h00, 0, 1, 0);
    tbl[13] = mk(8'h47, 0, 0, 0);
    tbl[14] = mk(8'h47, 0, 0, 0);
    tbl[15] = mk(8'h47, 0, 0, 0);
    tbl[16] = mk(8'h47, 1, 0, 1);

    ifa.byte_valid = 1'b0; ifa.byte_in = 8'h00;
    ifb.byte_valid = 1'b0; ifb.byte_in = 8'h00;
    repeat (2) @(posedge clk);

    // Continuous stream: lock, flywheel, unlock, re-lock
    do_reset(0);
    cur.delete();
    foreach (tbl[i]) cur.push_back(tbl[i]);
    run_pkts(0, 188, 1'b0);

    // Same stream with random byte_valid gaps
    do_reset(0);
    run_pkts(0, 188, 1'b1);

    // False sync at offset 50 while hunting, true alignment at offset 0
    do_reset(0);
    for (int p = 0; p < 7; p++) begin
      for (int off = (p == 0 ? 20 : 0); off < 188; off++) begin
        logic [7:0] b;
        b = pay();
        if (p == 0 && off == 50) b = 8'h47;
        if (p >= 1 && off == 0)  b = 8'h47;
        send(0, 1'b1, b, (p >= 5 && off == 0), 1'b0, (p >= 5));
      end
    end

    // 204-byte packets, lock after one confirmation, single miss drops lock
    do_reset(1);
    cur.delete();
    cur.push_back(mk(8'h47, 0, 0, 0));
    cur.push_back(mk(8'h47, 1, 0, 1));
    cur.push_back(mk(8'h47, 1, 0, 1));
    cur.push_back(mk(8'h00, 0, 1, 0));
    cur.push_back(mk(8'h47, 0, 0, 0));
    cur.push_back(mk(8'h47, 1, 0, 1));
    run_pkts(1, 204, 1'b0);

    // Reset mid-packet while locked, then full re-acquisition
    do_reset(0);
    cur.delete();
    cur.push_back(mk(8'h47, 0, 0, 0));
    cur.push_back(mk(8'h47, 0, 0, 0));
    cur.push_back(mk(8'h47, 0, 0, 0));
    cur.push_back(mk(8'h47, 1, 0, 1));
    run_pkts(0, 188, 1'b0);
    for (int off = 0; off < 100; off++)
      send(0, 1'b1, (off == 0) ? 8'h47 : pay(), (off == 0), 1'b0, 1'b1);
    do_reset(0);
    for (int off = 101; off < 188; off++)
      send(0, 1'b1, pay(), 1'b0, 1'b0, 1'b0);
    run_pkts(0, 188, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_sync_recovery_param.md
Name: ts_sync_recovery_param

Overview:
Parametrised MPEG-2 TS byte-stream sync recovery with hysteresis (flywheel) for one channel.
- Hunts for SYNC_BYTE and confirms it at PKT_LEN-byte spacing (188 plain, 204 with RS parity).
- Declares lock after LOCK_CNT consecutive confirmations; drops lock only after UNLOCK_CNT consecutive misses.
- Sits between the byte deserialiser and the packet-level QoS checkers. Replicated per channel by the top level.

Parameters:
PKT_LEN, 188, packet length in bytes (legal 188 or 204)
SYNC_BYTE, 8'h47, sync byte value
LOCK_CNT, 3, consecutive confirmed sync bytes (after the first) needed to lock; legal 1..15
UNLOCK_CNT, 3, consecutive missed sync bytes while locked that force re-hunt; legal 1..15
POS_W, 8, width of the byte-position counter; must satisfy 2^POS_W >= PKT_LEN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
byte_in  in  8  input stream byte
byte_valid  in  1  byte_in qualifier; one byte per cycle when high
byte_out  out  8  registered copy of byte_in
valid  out  1  registered byte_valid
sync  out  1  high with byte_out = first byte of a packet, only while locked
locked  out  1  high while in LOCKED state
sync_miss  out  1  one-cycle pulse, aligned with byte_out, when a locked packet boundary holds a non-sync byte

Behaviour:
- Reset (rst=1 at clk edge): state=HUNT, pos=0, hit=0, miss=0. Outputs byte_out=0, valid=0, sync=0, locked=0, sync_miss=0. Reset mid-packet discards all progress.
- Latency: every output is registered, 1 cycle after the accepted input byte.
- byte_valid=0 cycle:
  - State, pos, hit and miss hold.
  - valid=0, sync=0, sync_miss=0, byte_out=0.
  - Gaps of any length are transparent to packet counting.
- byte_valid=1 cycle: valid=1, byte_out=byte_in. pos counts 0..PKT_LEN-1 and wraps to 0. Boundary = accepted byte with pos==0.
- HUNT:
  - If byte_in==SYNC_BYTE: state→VERIFY, pos→1, hit→0.
  - Otherwise stay.
  - sync=0 throughout.
- VERIFY:
  - Non-boundary bytes: pos increments.
  - Boundary byte == SYNC_BYTE: hit+1. If hit+1==LOCK_CNT: state→LOCKED, miss→0, and sync=1 on this byte (the locking packet's first byte). Otherwise stay in VERIFY. pos→1 in both cases.
  - Boundary byte != SYNC_BYTE: state→HUNT, hit→0. The mismatching byte is not re-examined as a new candidate.
- LOCKED:
  - Boundary byte == SYNC_BYTE: sync=1, miss→0.
  - Boundary byte != SYNC_BYTE (flywheel): sync=1 anyway, sync_miss=1, miss+1.
  - If miss+1==UNLOCK_CNT: state→HUNT, locked→0 on the next output cycle, sync=0 and sync_miss=1 for this byte.
  - locked output = (state==LOCKED), registered alongside byte_out.
- Counter widths: hit and miss are 4 bits and cannot overflow given the legal parameter ranges. pos compare uses PKT_LEN-1 truncated to POS_W.
- Simultaneous rst and byte_valid: reset wins and the byte is dropped.

Optional Feature:
Macro TS_SYNC_STATS_EN.
- Defined: adds two outputs.
  - lock_loss_cnt (16-bit): increments on each LOCKED→HUNT transition.
  - pkt_cnt (32-bit): increments on each sync=1 output cycle.
  - Both saturate at all-ones, clear on rst, and are registered.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset then continuous 188-byte packets with 0x47 at offset 0 (defaults) → locked=1 and first sync=1 on the output cycle after the 4th 0x47 (hit reaches 3); sync pulses every 188 valid bytes thereafter; byte_out equals byte_in delayed 1 cycle.
2. Locked stream, corrupt one sync byte to 0x00 → sync=1 and sync_miss=1 on that byte, locked stays 1. The next good sync clears miss; three consecutive corrupt syncs → locked=0 after the third, sync=0 on it.
3. Random byte_valid gaps (≈50% duty) on a clean stream → same lock point counted in valid bytes; valid/sync/byte_out are 0 on gap cycles.
4. False 0x47 at offset 50 in HUNT, with the real sync at offset 0 → VERIFY fails at the boundary, returns to HUNT, then locks on the true alignment within 5 packets.
5. PKT_LEN=204, LOCK_CNT=1, UNLOCK_CNT=1 → locks on the second sync, sync period 204, and a single missed sync drops lock.
6. rst asserted mid-packet while locked → all outputs 0 the next cycle; re-lock needs the full LOCK_CNT+1 syncs. With TS_SYNC_STATS_EN, lock_loss_cnt and pkt_cnt read 0 after reset.
